// File: rtl/mod_bank.sv
// mod_bank: multi-channel PWM / first-order sigma-delta modulator with double-buffered levels
// Ports: clk, rstb (async, active low); enable runs the modulators;
//        valid/ch/level/mode write a channel shadow, answered by a one-cycle ack
//        (error alongside ack when ch is out of range); sync pulses at each
//        period boundary; out carries one registered modulated bit per channel.
module mod_bank #(
  parameter int C_CHANNELS    = 4,
  parameter int C_LEVEL_WIDTH = 8,
  parameter int C_PRESCALE    = 1,
  parameter int C_CH_WIDTH    = 2
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     enable,
  input  logic                     valid,
  input  logic [C_CH_WIDTH-1:0]    ch,
  input  logic [C_LEVEL_WIDTH-1:0] level,
  input  logic                     mode,
  output logic                     ack,
  output logic                     error,
  output logic                     sync,
  output logic [C_CHANNELS-1:0]    out
);
  localparam int W  = C_LEVEL_WIDTH;
  localparam int PW = (C_PRESCALE > 1) ? $clog2(C_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(C_PRESCALE - 1);
  localparam logic [C_CH_WIDTH:0] N_CH = (C_CH_WIDTH + 1)'(C_CHANNELS);
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0] p_q, p_d;
  logic run_q, run_d, sync_q, sync_d, ack_q, ack_d, error_q, error_d;
  logic [C_CHANNELS-1:0] out_q, out_d, sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [W-1:0] sh_lvl_q [C_CHANNELS];
  logic [W-1:0] sh_lvl_d [C_CHANNELS];
  logic [W-1:0] act_lvl_q [C_CHANNELS];
  logic [W-1:0] act_lvl_d [C_CHANNELS];
  logic [W-1:0] acc_q [C_CHANNELS];
  logic [W-1:0] acc_d [C_CHANNELS];
  logic tick, bnd, accept, hit;
  logic [W:0] sum;
  logic [W-1:0] base;
  // run_q is low after reset or while disabled, so the first tick behaves as a
  // boundary and starts a fresh period at p=0 with the current shadows.
  always_comb begin
    tick = enable && pre_q == PRE_MAX;
    bnd = tick && (!run_q || &p_q);
    pre_d = (!enable || tick) ? '0 : pre_q + 1'b1;
    p_d = (!enable || bnd) ? '0 : p_q + W'(tick);
    run_d = enable && (run_q || tick);
    sync_d = bnd;
    accept = valid && !ack_q;
    hit = accept && ({1'b0, ch} < N_CH);
    ack_d = accept;
    error_d = accept && !hit;
    sh_mode_d = sh_mode_q;
    act_mode_d = act_mode_q;
    out_d = out_q;
    sum = '0;
    base = '0;
    for (int i = 0; i < C_CHANNELS; i++) begin
      sh_lvl_d[i] = (hit && ch == C_CH_WIDTH'(i)) ? level : sh_lvl_q[i];
      sh_mode_d[i] = (hit && ch == C_CH_WIDTH'(i)) ? mode : sh_mode_q[i];
      act_lvl_d[i] = (bnd || !enable) ? sh_lvl_q[i] : act_lvl_q[i];
      act_mode_d[i] = (bnd || !enable) ? sh_mode_q[i] : act_mode_q[i];
      // a mode change at a boundary restarts the accumulator from zero
      base = (bnd && act_mode_d[i] != act_mode_q[i]) ? '0 : acc_q[i];
      sum = {1'b0, base} + {1'b0, act_lvl_d[i]};
      acc_d[i] = !enable ? '0 : (tick && act_mode_d[i]) ? sum[W-1:0] : base;
      out_d[i] = !enable ? 1'b0 : !tick ? out_q[i] : act_mode_d[i] ? sum[W] : (act_lvl_d[i] > p_d);
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pre_q <= '0;
      p_q <= '0;
      run_q <= 1'b0;
      sync_q <= 1'b0;
      ack_q <= 1'b0;
      error_q <= 1'b0;
      out_q <= '0;
      sh_mode_q <= '0;
      act_mode_q <= '0;
      for (int i = 0; i < C_CHANNELS; i++) begin
        sh_lvl_q[i] <= '0;
        act_lvl_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      pre_q <= pre_d;
      p_q <= p_d;
      run_q <= run_d;
      sync_q <= sync_d;
      ack_q <= ack_d;
      error_q <= error_d;
      out_q <= out_d;
      sh_mode_q <= sh_mode_d;
      act_mode_q <= act_mode_d;
      sh_lvl_q <= sh_lvl_d;
      act_lvl_q <= act_lvl_d;
      acc_q <= acc_d;
    end
  end
  assign ack = ack_q;
  assign error = error_q;
  assign sync = sync_q;
  assign out = out_q;
endmodule

// File: tb/tb_mod_bank.sv
// tb_mod_bank: scoreboard bench for mod_bank (default, 3-channel and prescale-4 instances)
module tb_mod_bank;
  typedef struct packed {
    logic [1:0] inst;
    logic [11:0] spacing;
    logic [3:0][9:0] highs;
    logic [3:0][9:0] rises;
  } rec_t;
  typedef struct packed {
    logic [1:0] inst;
    logic err;
  } ack_t;
  logic clk, rstb;
  logic [2:0] en, vld, md;
  logic [1:0] chs [3];
  logic [7:0] lvl [3];
  logic [3:0] out_a, out_c;
  logic [2:0] out_b;
  logic [2:0] acks, errs, syncs;
  logic [3:0] outs [3];
  rec_t pq[$];
  ack_t aq[$];
  int n_vec = 0, n_fail = 0;
  int cnt [3];
  int hi [3][4];
  int ri [3][4];
  logic [3:0] prev [3];
  mod_bank u_a (.clk(clk), .rstb(rstb), .enable(en[0]), .valid(vld[0]), .ch(chs[0]), .level(lvl[0]),
    .mode(md[0]), .ack(acks[0]), .error(errs[0]), .sync(syncs[0]), .out(out_a));
  mod_bank #(.C_CHANNELS(3)) u_b (.clk(clk), .rstb(rstb), .enable(en[1]), .valid(vld[1]), .ch(chs[1]),
    .level(lvl[1]), .mode(md[1]), .ack(acks[1]), .error(errs[1]), .sync(syncs[1]), .out(out_b));
  mod_bank #(.C_PRESCALE(4)) u_c (.clk(clk), .rstb(rstb), .enable(en[2]), .valid(vld[2]), .ch(chs[2]),
    .level(lvl[2]), .mode(md[2]), .ack(acks[2]), .error(errs[2]), .sync(syncs[2]), .out(out_c));
  assign outs[0] = out_a;
  assign outs[1] = {1'b0, out_b};
  assign outs[2] = out_c;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic rec_t mk(input int k, input int sp, input int h0, input int h1, input int h2,
                              input int h3, input int r0, input int r1, input int r2, input int r3);
    rec_t r;
    r.inst = 2'(k);
    r.spacing = 12'(sp);
    r.highs = {10'(h3), 10'(h2), 10'(h1), 10'(h0)};
    r.rises = {10'(r3), 10'(r2), 10'(r1), 10'(r0)};
    return r;
  endfunction
  // Monitor: closes a per-instance period record at every sync, and matches every ack.
  initial begin
    rec_t r;
    ack_t a;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      prev[k] = '0;
      for (int j = 0; j < 4; j++) begin
        hi[k][j] = 0;
        ri[k][j] = 0;
      end
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (syncs[k]) begin
          if (pq.size() > 0 && int'(pq[0].inst) == k) begin
            r = pq.pop_front();
            chk($sformatf("inst%0d_sync_spacing", k), cnt[k], int'(r.spacing));
            for (int j = 0; j < 4; j++) begin
              chk($sformatf("inst%0d_highs_ch%0d", k, j), hi[k][j], int'(r.highs[j]));
              chk($sformatf("inst%0d_runs_ch%0d", k, j), ri[k][j], int'(r.rises[j]));
            end
          end
          cnt[k] = 0;
          for (int j = 0; j < 4; j++) begin
            hi[k][j] = 0;
            ri[k][j] = 0;
          end
        end
        cnt[k]++;
        for (int j = 0; j < 4; j++) begin
          hi[k][j] += int'(outs[k][j]);
          ri[k][j] += int'(outs[k][j] && !prev[k][j]);
        end
        prev[k] = outs[k];
        if (acks[k]) begin
          if (aq.size() > 0 && int'(aq[0].inst) == k) begin
            a = aq.pop_front();
            chk($sformatf("inst%0d_ack_error", k), int'(errs[k]), int'(a.err));
          end else chk($sformatf("inst%0d_unexpected_ack", k), 1, 0);
        end else if (errs[k]) chk($sformatf("inst%0d_error_without_ack", k), 1, 0);
      end
    end
  end
  task automatic wait_sync(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!syncs[k] && n < 3000);
    if (!syncs[k]) chk($sformatf("inst%0d_sync_timeout", k), 0, 1);
    #1;
  endtask
  task automatic wr(input int k, input logic [1:0] c, input logic [7:0] l, input logic m, input logic e);
    int n;
    vld[k] = 1'b1;
    chs[k] = c;
    lvl[k] = l;
    md[k] = m;
    aq.push_back('{inst: 2'(k), err: e});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acks[k] && n < 10);
    if (!acks[k]) chk($sformatf("inst%0d_ack_timeout", k), 0, 1);
    vld[k] = 1'b0;
  endtask
  initial begin
    int n;
    rstb = 1'b0;
    en = 3'b111;
    vld = '0;
    md = '0;
    for (int k = 0; k < 3; k++) begin
      chs[k] = '0;
      lvl[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_out_a", int'(out_a), 0);
    chk("reset_out_b", int'(out_b), 0);
    chk("reset_out_c", int'(out_c), 0);
    chk("reset_sync_ack_error", int'({syncs, acks, errs}), 0);
    rstb = 1'b1;
    // idle: no activity, sync every 256 cycles
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 0, 0, 0, 0, 0, 0, 0, 0));
    wait_sync(0, n);
    // ch1 PWM 64
    repeat (10) @(negedge clk);
    wr(0, 2'd1, 8'd64, 1'b0, 1'b0);
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 0, 64, 0, 0, 0, 1, 0, 0));
    wait_sync(0, n);
    // ch2 sigma-delta 128, then 1
    wr(0, 2'd2, 8'd128, 1'b1, 1'b0);
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 0, 64, 128, 0, 0, 1, 128, 0));
    wait_sync(0, n);
    wr(0, 2'd2, 8'd1, 1'b1, 1'b0);
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 0, 64, 1, 0, 0, 1, 1, 0));
    wait_sync(0, n);
    // mid-period write of ch0 at p=100 does not affect the current period
    pq.push_back(mk(0, 256, 0, 64, 1, 0, 0, 1, 1, 0));
    repeat (100) @(negedge clk);
    wr(0, 2'd0, 8'd200, 1'b0, 1'b0);
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 200, 64, 1, 0, 1, 1, 1, 0));
    // write accepted exactly on the next boundary edge applies one period later
    repeat (255) @(negedge clk);
    wr(0, 2'd3, 8'd50, 1'b0, 1'b0);
    #1;
    pq.push_back(mk(0, 256, 200, 64, 1, 0, 1, 1, 1, 0));
    wait_sync(0, n);
    pq.push_back(mk(0, 256, 200, 64, 1, 50, 1, 1, 1, 1));
    wait_sync(0, n);
    // three-channel instance: out-of-range channel
    wr(1, 2'd0, 8'd30, 1'b0, 1'b0);
    wr(1, 2'd3, 8'd99, 1'b1, 1'b1);
    wait_sync(1, n);
    pq.push_back(mk(1, 256, 30, 0, 0, 0, 1, 0, 0, 0));
    wait_sync(1, n);
    // prescale 4
    wait_sync(2, n);
    pq.push_back(mk(2, 1024, 0, 0, 0, 0, 0, 0, 0, 0));
    wait_sync(2, n);
    wr(2, 2'd0, 8'd10, 1'b0, 1'b0);
    wait_sync(2, n);
    pq.push_back(mk(2, 1024, 40, 0, 0, 0, 1, 0, 0, 0));
    wait_sync(2, n);
    // enable low mid-period, write while disabled, re-enable
    repeat (20) @(negedge clk);
    chk("c_out_before_disable", int'(out_c), 1);
    repeat (280) @(negedge clk);
    en[2] = 1'b0;
    @(negedge clk);
    chk("c_out_after_disable", int'(out_c), 0);
    chk("c_sync_after_disable", int'(syncs[2]), 0);
    wr(2, 2'd1, 8'd5, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("c_out_while_disabled", int'(out_c), 0);
    en[2] = 1'b1;
    wait_sync(2, n);
    chk("c_reenable_first_tick", n, 4);
    pq.push_back(mk(2, 1024, 40, 20, 0, 0, 1, 1, 0, 0));
    wait_sync(2, n);
    // async reset mid-period
    repeat (200) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("async_reset_out_a", int'(out_a), 0);
    chk("async_reset_out_b", int'(out_b), 0);
    chk("async_reset_out_c", int'(out_c), 0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    wait_sync(2, n);
    pq.push_back(mk(2, 1024, 0, 0, 0, 0, 0, 0, 0, 0));
    wait_sync(2, n);
    chk("a_out_after_reset", int'(out_a), 0);
    chk("pending_period_records", pq.size(), 0);
    chk("pending_acks", aq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
